// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared definitions for the immediate encoder.
//   imm_fmt_e    : immediate format select codes (I/S/B/J/U), same codes
//                  as the immediate-extension select used elsewhere.
//   enc_state_e  : encoder control states.
//   encode_instr : places an immediate and register fields into a
//                  32-bit instruction word for a given format.
package riscv_pkg;

    typedef enum logic [2:0] {
        FMT_I = 3'b000,
        FMT_S = 3'b001,
        FMT_B = 3'b010,
        FMT_J = 3'b011,
        FMT_U = 3'b100
    } imm_fmt_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } enc_state_e;

    // Fields a format does not use are simply not referenced for it.
    // Codes 101-111 never reach here with a meaningful result because
    // the range check rejects them; they map to zero.
    function automatic logic [31:0] encode_instr(
        input logic [2:0]  fmt,
        input logic [31:0] imm,
        input logic [6:0]  opcode,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  funct3
    );
        logic [31:0] word;
        word = '0;
        case (fmt)
            FMT_I:   word = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, funct3,
                             imm[4:1], imm[11], opcode};
            FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            FMT_U:   word = {imm[31:12], rd, opcode};
            default: word = '0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/imm_range_check.sv
// imm_range_check -- combinational check that a sign-extended immediate
// can be represented exactly by the chosen instruction format.
//   fmt_i : format select (000 I, 001 S, 010 B, 011 J, 100 U, others illegal)
//   imm_i : sign-extended immediate
//   ok_o  : 1 when encoding imm_i in fmt_i loses no information
module imm_range_check
    import riscv_pkg::*;
(
    input  logic [2:0]  fmt_i,
    input  logic [31:0] imm_i,
    output logic        ok_o
);

    // "All equal" over the upper bits means the value is a pure sign
    // extension of the bits the format actually stores.
    logic fits_12;
    logic fits_13;
    logic fits_21;
    logic low_clear;

    assign fits_12   = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    assign fits_13   = (&imm_i[31:12]) | ~(|imm_i[31:12]);
    assign fits_21   = (&imm_i[31:20]) | ~(|imm_i[31:20]);
    assign low_clear = ~(|imm_i[11:0]);

    always_comb begin
        ok_o = 1'b0;
        case (fmt_i)
            FMT_I, FMT_S: ok_o = fits_12;
            // Branch and jump offsets are halfword aligned; bit 0 is not stored.
            FMT_B:        ok_o = fits_13 & ~imm_i[0];
            FMT_J:        ok_o = fits_21 & ~imm_i[0];
            FMT_U:        ok_o = low_clear;
            default:      ok_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/immediate_encoder.sv
// immediate_encoder -- accepts an encode request (format, immediate,
// register fields), rejects immediates the format cannot hold, and
// presents accepted instruction words with a running word address.
//   clk, rst_n              : clock (rising edge), async active-low reset
//   in_valid/in_ready       : request handshake
//   in_fmt, in_imm, in_*    : request contents
//   out_valid/out_ready     : encoded word handshake
//   out_instr, out_addr     : encoded word and its address
//   addr_load, addr_value   : reload of the address counter (IDLE only)
//   err, err_count          : reject pulse and saturating reject count
module immediate_encoder
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_fmt,
    input  logic [31:0]          in_imm,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [31:0]          out_addr,
    input  logic                 addr_load,
    input  logic [31:0]          addr_value,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count
);

    enc_state_e            state_q, state_d;
    logic                  rdy_q;
    logic [31:0]           instr_q, instr_d;
    logic [31:0]           addr_q, addr_d;
    logic                  err_q, err_d;
    logic [ERR_CNT_W-1:0]  cnt_q, cnt_d;
    logic                  imm_ok;
    logic                  take_req;

    imm_range_check u_range (
        .fmt_i (in_fmt),
        .imm_i (in_imm),
        .ok_o  (imm_ok)
    );

    // rdy_q keeps in_ready low throughout reset even though the state
    // register already sits in IDLE; it rises on the first edge after release.
    assign in_ready  = rdy_q && (state_q == ST_IDLE);
    assign take_req  = in_ready && in_valid;
    assign out_valid = (state_q == ST_HOLD);
    assign out_instr = instr_q;
    assign out_addr  = addr_q;
    assign err       = err_q;
    assign err_count = cnt_q;

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                // A load coinciding with an accepted request becomes that
                // request's address, since the word is issued from addr_q.
                if (addr_load) begin
                    addr_d = addr_value;
                end
                if (take_req) begin
                    if (imm_ok) begin
                        state_d = ST_HOLD;
                        instr_d = encode_instr(in_fmt, in_imm, in_opcode, in_rd,
                                               in_rs1, in_rs2, in_funct3);
                    end else begin
                        err_d = 1'b1;
                        if (cnt_q != {ERR_CNT_W{1'b1}}) begin
                            cnt_d = cnt_q + ERR_CNT_W'(1);
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    addr_d  = addr_q + 32'd4;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b0;
            instr_q <= '0;
            addr_q  <= RESET_ADDR;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_immediate_encoder.sv
module tb_immediate_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_fmt = '0;
    logic [31:0] in_imm = '0;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        addr_load = 1'b0;
    logic [31:0] addr_value = '0;
    logic        err;
    logic [7:0]  err_count;

    int errors = 0;
    int checks = 0;

    immediate_encoder #(.RESET_ADDR(32'h0000_0000), .ERR_CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_fmt     (in_fmt),
        .in_imm     (in_imm),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_addr   (out_addr),
        .addr_load  (addr_load),
        .addr_value (addr_value),
        .err        (err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Representability by value range, not by bit patterns.
    function automatic bit legal(input logic [2:0] fmt, input logic [31:0] imm);
        longint s;
        s = longint'($signed(imm));
        case (fmt)
            3'd0, 3'd1: return (s >= -2048) && (s <= 2047);
            3'd2:       return (s >= -4096) && (s <= 4095) && (imm % 2 == 0);
            3'd3:       return (s >= -(64'sd1 << 20)) && (s < (64'sd1 << 20)) && (imm % 2 == 0);
            3'd4:       return (imm % 4096) == 0;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_encode(input logic [2:0] f, input logic [31:0] m,
                                               input logic [6:0] op, input logic [4:0] rd,
                                               input logic [4:0] r1, input logic [4:0] r2,
                                               input logic [2:0] f3);
        case (f)
            3'd0: return {m[11:0], r1, f3, rd, op};
            3'd1: return {m[11:5], r2, r1, f3, m[4:0], op};
            3'd2: return {m[12], m[10:5], r2, r1, f3, m[4:1], m[11], op};
            3'd3: return {m[20], m[10:1], m[11], m[19:12], rd, op};
            default: return {m[31:12], rd, op};
        endcase
    endfunction

    // Re-extend the immediate from an encoded word.
    function automatic logic [31:0] decode_imm(input logic [2:0] f, input logic [31:0] x);
        case (f)
            3'd0: return {{20{x[31]}}, x[31:20]};
            3'd1: return {{20{x[31]}}, x[31:25], x[11:7]};
            3'd2: return {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
            3'd3: return {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
            default: return {x[31:12], 12'h000};
        endcase
    endfunction

    // Transaction-level reference: a pending word, its address, rejects so far.
    bit          m_rdy;
    bit          m_hold;
    logic [31:0] m_instr;
    logic [31:0] m_addr;
    logic [2:0]  m_fmt;
    logic [31:0] m_imm;
    bit          m_err;
    int          m_rej;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rdy <= 0; m_hold <= 0; m_instr <= '0; m_addr <= 32'h0;
            m_err <= 0; m_rej <= 0; m_fmt <= '0; m_imm <= '0;
        end else begin
            m_rdy <= 1;
            m_err <= 0;
            if (m_hold) begin
                if (out_ready) begin
                    m_hold <= 0;
                    m_addr <= m_addr + 32'd4;
                end
            end else begin
                if (addr_load) m_addr <= addr_value;
                if (m_rdy && in_valid) begin
                    if (legal(in_fmt, in_imm)) begin
                        m_hold  <= 1;
                        m_instr <= ref_encode(in_fmt, in_imm, in_opcode, in_rd,
                                              in_rs1, in_rs2, in_funct3);
                        m_fmt   <= in_fmt;
                        m_imm   <= in_imm;
                    end else begin
                        m_err <= 1;
                        m_rej <= m_rej + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(m_rdy && !m_hold));
        chk("out_valid", 32'(out_valid), 32'(m_hold));
        chk("err", 32'(err), 32'(m_err));
        chk("err_count", 32'(err_count), (m_rej > 255) ? 32'd255 : 32'(m_rej));
        chk("out_addr", out_addr, m_addr);
        chk("out_instr", out_instr, m_instr);
        if (out_valid) chk("round_trip", decode_imm(m_fmt, out_instr), m_imm);
    end

    task automatic send(input logic [2:0] f, input logic [31:0] m, input logic [6:0] op,
                        input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [2:0] f3, input int hold, input bit ld, input logic [31:0] ldv);
        int n;
        n = 0;
        while ((m_hold || !m_rdy) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (m_hold || !m_rdy) chk("wait_idle_timeout", 32'd1, 32'd0);
        in_fmt = f; in_imm = m; in_opcode = op; in_rd = rd; in_rs1 = r1;
        in_rs2 = r2; in_funct3 = f3; addr_load = ld; addr_value = ldv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; addr_load = 1'b0;
        $display("txn fmt=%0d imm=%h %s addr=%h", f, m, m_hold ? "accepted" : "rejected", m_addr);
        if (m_hold) begin
            repeat (hold) begin @(posedge clk); #1; end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] t;
        logic [31:0] imm;
        logic [2:0]  f;
        int          w;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_release", 32'(in_ready), 32'd1);

        // I-type with 5 cycles of backpressure.
        in_fmt = 3'd0; in_imm = 32'hFFFF_FFFF; in_rs1 = 5'd2; in_funct3 = 3'd0;
        in_rd = 5'd1; in_opcode = 7'h13; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("i_valid", 32'(out_valid), 32'd1);
        chk("i_instr", out_instr, 32'hFFF1_0093);
        chk("i_addr", out_addr, 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_instr", out_instr, 32'hFFF1_0093);
            chk("bp_addr", out_addr, 32'h0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_addr_step", out_addr, 32'h4);
        chk("bp_valid_low", 32'(out_valid), 32'd0);

        // B-type accept, then a misaligned offset that must be rejected.
        in_fmt = 3'd2; in_imm = 32'hFFFF_FFFC; in_rs1 = 5'd1; in_rs2 = 5'd2;
        in_funct3 = 3'd1; in_opcode = 7'h63; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b_instr", out_instr, 32'hFE20_9EE3);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_imm = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b_err_pulse", 32'(err), 32'd1);
        chk("b_err_count", 32'(err_count), 32'd1);
        chk("b_no_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("b_err_clear", 32'(err), 32'd0);

        // U-type with a coincident address load at the wrap point.
        in_fmt = 3'd4; in_imm = 32'h1234_5000; in_rd = 5'd5; in_opcode = 7'h37;
        addr_load = 1'b1; addr_value = 32'hFFFF_FFFC; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; addr_load = 1'b0;
        chk("u_instr", out_instr, 32'h1234_52B7);
        chk("u_addr", out_addr, 32'hFFFF_FFFC);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("u_wrap", out_addr, 32'h0);

        // Random requests, mostly representable, all formats.
        for (int k = 0; k < 200; k++) begin
            f = 3'($urandom_range(0, 4));
            r = $urandom;
            case (f)
                3'd0, 3'd1: w = 12;
                3'd2:       w = 13;
                3'd3:       w = 21;
                default:    w = 32;
            endcase
            if (w == 32) begin
                imm = r & 32'hFFFF_F000;
            end else begin
                t = r << (32 - w);
                imm = 32'($signed(t) >>> (32 - w));
                if (f == 3'd2 || f == 3'd3) imm = imm & 32'hFFFF_FFFE;
            end
            if ($urandom_range(0, 9) == 0) imm = $urandom;
            send(f, imm, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 3'($urandom), $urandom_range(0, 3), ($urandom_range(0, 7) == 0), $urandom);
        end

        // Reset while a word is pending.
        while (m_hold) begin @(posedge clk); #1; end
        in_fmt = 3'd0; in_imm = 32'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst_hold", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_hold_valid", 32'(out_valid), 32'd0);
        chk("rst_hold_addr", out_addr, 32'h0);
        chk("rst_hold_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Illegal formats until the reject count saturates.
        for (int k = 0; k < 300; k++) begin
            send(3'($urandom_range(5, 7)), $urandom, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 0, 1'b0, 32'h0);
        end
        @(posedge clk); #1;
        chk("err_saturate", 32'(err_count), 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
